// File: rtl/fft_pkg.sv
// Shared definitions for the FFT peak finder.
//   state_t  : frame-tracking FSM state (IDLE / FRAME)
//   PIPE_LAT : beat-to-result latency in clk cycles (square, sum, compare)
package fft_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_FRAME = 1'b1
   } state_t;

   localparam int PIPE_LAT = 3;

endpackage

// File: rtl/fft_peak_pwr.sv
// Pipelined magnitude-squared of one spectrum bin.
// Stage 1 registers Re^2 and Im^2, stage 2 registers their sum. The frame
// markers, the valid bit and the raw bin value travel alongside the data so
// that everything leaving this block belongs to the same beat.
// Ports:
//   clk, aclr                     : clock, synchronous active-high reset
//   sink_valid/sop/eop            : incoming beat qualifiers
//   sink_re, sink_im              : signed bin value
//   pwr_valid/sop/eop             : qualifiers delayed by two cycles
//   pwr_re, pwr_im                : bin value delayed by two cycles
//   pwr                           : Re^2 + Im^2, full precision, unsigned
module fft_peak_pwr #(
   parameter int RES_WIDTH = 26
) (
   input  logic                         clk,
   input  logic                         aclr,
   input  logic                         sink_valid,
   input  logic                         sink_sop,
   input  logic                         sink_eop,
   input  logic signed [RES_WIDTH-1:0]  sink_re,
   input  logic signed [RES_WIDTH-1:0]  sink_im,
   output logic                         pwr_valid,
   output logic                         pwr_sop,
   output logic                         pwr_eop,
   output logic signed [RES_WIDTH-1:0]  pwr_re,
   output logic signed [RES_WIDTH-1:0]  pwr_im,
   output logic [2*RES_WIDTH-1:0]       pwr
);

   logic                         s1_valid, s1_sop, s1_eop;
   logic signed [RES_WIDTH-1:0]  s1_re, s1_im;
   logic signed [2*RES_WIDTH-1:0] sq_re, sq_im;

   // A square is never negative and is at most 2^(2W-2), so the unsigned
   // sum of two squares always fits in 2W bits without overflow.
   always_ff @(posedge clk) begin
      if (aclr) begin
         s1_valid  <= 1'b0;
         s1_sop    <= 1'b0;
         s1_eop    <= 1'b0;
         s1_re     <= '0;
         s1_im     <= '0;
         sq_re     <= '0;
         sq_im     <= '0;
         pwr_valid <= 1'b0;
         pwr_sop   <= 1'b0;
         pwr_eop   <= 1'b0;
         pwr_re    <= '0;
         pwr_im    <= '0;
         pwr       <= '0;
      end else begin
         s1_valid  <= sink_valid;
         s1_sop    <= sink_sop;
         s1_eop    <= sink_eop;
         s1_re     <= sink_re;
         s1_im     <= sink_im;
         sq_re     <= sink_re * sink_re;
         sq_im     <= sink_im * sink_im;
         pwr_valid <= s1_valid;
         pwr_sop   <= s1_sop;
         pwr_eop   <= s1_eop;
         pwr_re    <= s1_re;
         pwr_im    <= s1_im;
         pwr       <= $unsigned(sq_re) + $unsigned(sq_im);
      end
   end

endmodule

// File: rtl/fft_peak_find.sv
// Finds the highest-power bin in each FFT output frame of N = 2**POW bins.
// Streaming interface: valid-only, no backpressure. A beat is taken on every
// rising clk edge where sink_valid is high; sink_sop/sink_eop are meaningful
// only on such beats. The block accepts one beat per cycle indefinitely.
// Results appear PIPE_LAT cycles after the closing beat as a one-cycle
// peak_valid strobe; peak_* hold until the next strobe. Framing violations
// give a one-cycle frame_error strobe with the same latency.
// Build option: define FFT_PEAK_SKIP_DC_EN to exclude bin 0 from the search.
// Ports:
//   clk, aclr              : clock, synchronous active-high reset
//   sink_sop/eop/valid     : frame markers and beat qualifier
//   sink_Re, sink_Im       : signed bin value
//   peak_valid             : result strobe
//   peak_bin/pwr/Re/Im     : index, power and raw value of the peak bin
//   frame_error            : framing violation strobe
//   state_dbg              : current FSM state (0 = IDLE, 1 = FRAME)
module fft_peak_find
   import fft_pkg::*;
#(
   parameter int POW       = 12,
   parameter int RES_WIDTH = 26
) (
   input  logic                         clk,
   input  logic                         aclr,
   input  logic                         sink_sop,
   input  logic                         sink_eop,
   input  logic                         sink_valid,
   input  logic signed [RES_WIDTH-1:0]  sink_Re,
   input  logic signed [RES_WIDTH-1:0]  sink_Im,
   output logic                         peak_valid,
   output logic [POW-1:0]               peak_bin,
   output logic [2*RES_WIDTH-1:0]       peak_pwr,
   output logic signed [RES_WIDTH-1:0]  peak_Re,
   output logic signed [RES_WIDTH-1:0]  peak_Im,
   output logic                         frame_error,
   output logic                         state_dbg
);

   localparam logic [POW-1:0] BIN_LAST = '1;
   localparam logic [POW-1:0] BIN_ONE  = POW'(1);

   logic                         p_valid, p_sop, p_eop;
   logic signed [RES_WIDTH-1:0]  p_re, p_im;
   logic [2*RES_WIDTH-1:0]       p_pwr;

   fft_peak_pwr #(
      .RES_WIDTH (RES_WIDTH)
   ) u_pwr (
      .clk        (clk),
      .aclr       (aclr),
      .sink_valid (sink_valid),
      .sink_sop   (sink_sop),
      .sink_eop   (sink_eop),
      .sink_re    (sink_Re),
      .sink_im    (sink_Im),
      .pwr_valid  (p_valid),
      .pwr_sop    (p_sop),
      .pwr_eop    (p_eop),
      .pwr_re     (p_re),
      .pwr_im     (p_im),
      .pwr        (p_pwr)
   );

   state_t                       state_q, state_d;
   logic [POW-1:0]               cnt_q, cnt_d, nxt;
   logic [2*RES_WIDTH-1:0]       max_pwr_q, max_pwr_d;
   logic [POW-1:0]               max_bin_q, max_bin_d;
   logic signed [RES_WIDTH-1:0]  max_re_q, max_re_d, max_im_q, max_im_d;
   logic                         take, close, err;

   assign state_dbg = state_q;
   assign nxt       = cnt_q + BIN_ONE;

   // Strictly-greater keeps the lowest index on ties. With DC skipped the
   // running max loaded from bin 0 is unconditionally replaced by bin 1.
`ifdef FFT_PEAK_SKIP_DC_EN
   assign take = (p_pwr > max_pwr_q) || (nxt == BIN_ONE);
`else
   assign take = (p_pwr > max_pwr_q);
`endif

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      max_pwr_d = max_pwr_q;
      max_bin_d = max_bin_q;
      max_re_d  = max_re_q;
      max_im_d  = max_im_q;
      close     = 1'b0;
      err       = 1'b0;
      if (p_valid) begin
         if (p_sop) begin
            // A sop inside an open frame aborts it and restarts from here.
            if (state_q == ST_FRAME) err = 1'b1;
            if (p_eop) begin
               // Single-beat frame can never be length N (N > 1).
               err     = 1'b1;
               state_d = ST_IDLE;
            end else begin
               state_d   = ST_FRAME;
               cnt_d     = '0;
               max_pwr_d = p_pwr;
               max_bin_d = '0;
               max_re_d  = p_re;
               max_im_d  = p_im;
            end
         end else if (state_q == ST_FRAME) begin
            if (take) begin
               max_pwr_d = p_pwr;
               max_bin_d = nxt;
               max_re_d  = p_re;
               max_im_d  = p_im;
            end
            if (nxt == BIN_LAST) begin
               state_d = ST_IDLE;
               if (p_eop) close = 1'b1;
               else       err   = 1'b1;
            end else if (p_eop) begin
               err     = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_d = nxt;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (aclr) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         max_pwr_q   <= '0;
         max_bin_q   <= '0;
         max_re_q    <= '0;
         max_im_q    <= '0;
         peak_valid  <= 1'b0;
         frame_error <= 1'b0;
         peak_bin    <= '0;
         peak_pwr    <= '0;
         peak_Re     <= '0;
         peak_Im     <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         max_pwr_q   <= max_pwr_d;
         max_bin_q   <= max_bin_d;
         max_re_q    <= max_re_d;
         max_im_q    <= max_im_d;
         peak_valid  <= close;
         frame_error <= err;
         if (close) begin
            peak_bin <= max_bin_d;
            peak_pwr <= max_pwr_d;
            peak_Re  <= max_re_d;
            peak_Im  <= max_im_d;
         end
      end
   end

endmodule

// File: tb/tb_fft_peak_find.sv
module tb_fft_peak_find;

   localparam int POW = 4;
   localparam int RW  = 8;
   localparam int N   = 16;

   logic          clk = 1'b0;
   logic          aclr;
   logic          sink_sop, sink_eop, sink_valid;
   logic [RW-1:0] sink_Re, sink_Im;
   logic          peak_valid, frame_error, state_dbg;
   logic [POW-1:0]  peak_bin;
   logic [2*RW-1:0] peak_pwr;
   logic [RW-1:0]   peak_Re, peak_Im;

   fft_peak_find #(.POW(POW), .RES_WIDTH(RW)) dut (
      .clk         (clk),
      .aclr        (aclr),
      .sink_sop    (sink_sop),
      .sink_eop    (sink_eop),
      .sink_valid  (sink_valid),
      .sink_Re     (sink_Re),
      .sink_Im     (sink_Im),
      .peak_valid  (peak_valid),
      .peak_bin    (peak_bin),
      .peak_pwr    (peak_pwr),
      .peak_Re     (peak_Re),
      .peak_Im     (peak_Im),
      .frame_error (frame_error),
      .state_dbg   (state_dbg)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   int n_total = 0;
   int n_bad   = 0;
   int pv_cnt  = 0;
   int fe_cnt  = 0;
   int exp_pv  = 0;
   int exp_fe  = 0;
   logic [35:0] exp_q[$];   // {bin[4], pwr[16], re[8], im[8]}

   logic [RW-1:0] fre[N];
   logic [RW-1:0] fim[N];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic void exp_push(input logic [3:0] b, input logic [15:0] p,
                                    input logic [7:0] r, input logic [7:0] i);
      exp_q.push_back({b, p, r, i});
      exp_pv++;
   endfunction

   always @(negedge clk) begin
      if (frame_error) fe_cnt++;
      if (peak_valid) begin
         pv_cnt++;
         if (exp_q.size() == 0) begin
            chk("pv_unexpected", 64'(peak_valid), 64'd0);
         end else begin
            logic [35:0] e;
            e = exp_q.pop_front();
            chk("sb_bin", 64'(peak_bin), 64'(e[35:32]));
            chk("sb_pwr", 64'(peak_pwr), 64'(e[31:16]));
            chk("sb_re",  64'(peak_Re),  64'(e[15:8]));
            chk("sb_im",  64'(peak_Im),  64'(e[7:0]));
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic clear_frame();
      for (int k = 0; k < N; k++) begin
         fre[k] = '0;
         fim[k] = '0;
      end
   endtask

   // Drives bins first..last of the stored frame; sop on bin 0, eop on 'last'
   // when requested. Gap cycles carry junk with valid low.
   task automatic send_bins(input int first, input int last, input bit with_eop, input bit gaps);
      for (int k = first; k <= last; k++) begin
         sink_valid = 1'b1;
         sink_sop   = (k == 0);
         sink_eop   = with_eop && (k == last);
         sink_Re    = fre[k];
         sink_Im    = fim[k];
         tick();
         sink_valid = 1'b0;
         sink_sop   = 1'b0;
         sink_eop   = 1'b0;
         if (gaps) begin
            sink_sop = 1'b1;
            sink_eop = 1'b1;
            sink_Re  = RW'($urandom_range(0, 255));
            sink_Im  = RW'($urandom_range(0, 255));
            tick();
            sink_sop = 1'b0;
            sink_eop = 1'b0;
         end
      end
   endtask

   task automatic check_counts(input string tag);
      idle(6);
      chk({tag, "_pv"}, 64'(pv_cnt), 64'(exp_pv));
      chk({tag, "_fe"}, 64'(fe_cnt), 64'(exp_fe));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      aclr = 1'b1;
      sink_valid = 1'b0;
      sink_sop = 1'b0;
      sink_eop = 1'b0;
      sink_Re = '0;
      sink_Im = '0;
      idle(3);
      aclr = 1'b0;
      tick();

      // Reset state
      chk("rst_pv",    64'(peak_valid),  64'd0);
      chk("rst_fe",    64'(frame_error), 64'd0);
      chk("rst_bin",   64'(peak_bin),    64'd0);
      chk("rst_pwr",   64'(peak_pwr),    64'd0);
      chk("rst_re",    64'(peak_Re),     64'd0);
      chk("rst_im",    64'(peak_Im),     64'd0);
      chk("rst_state", 64'(state_dbg),   64'd0);

      // Single peak at bin 5 = (3,4), latency check
      clear_frame();
      fre[5] = 8'd3;
      fim[5] = 8'd4;
      exp_push(4'd5, 16'd25, 8'd3, 8'd4);
      send_bins(0, 15, 1'b1, 1'b0);
      tick();
      chk("lat_early", 64'(peak_valid), 64'd0);
      tick();
      chk("lat_on",    64'(peak_valid), 64'd1);
      chk("lat_bin",   64'(peak_bin),   64'd5);
      chk("lat_pwr",   64'(peak_pwr),   64'd25);
      tick();
      chk("lat_pulse", 64'(peak_valid), 64'd0);
      chk("idle_state", 64'(state_dbg), 64'd0);
      check_counts("t1");

      // Tie: bins 2 and 9 = (-7,0); lowest index wins
      clear_frame();
      fre[2] = 8'hF9;
      fre[9] = 8'hF9;
      exp_push(4'd2, 16'd49, 8'hF9, 8'h00);
      send_bins(0, 15, 1'b1, 1'b0);
      check_counts("t2");

      // Early eop at bin 10: error only, outputs hold previous result
      clear_frame();
      fre[4] = 8'd90;
      exp_fe++;
      send_bins(0, 10, 1'b1, 1'b0);
      check_counts("t3");
      chk("hold_bin", 64'(peak_bin), 64'd2);
      chk("hold_pwr", 64'(peak_pwr), 64'd49);

      // Good frame after the error: bin 7 = (0,-5)
      clear_frame();
      fim[7] = 8'hFB;
      exp_push(4'd7, 16'd25, 8'h00, 8'hFB);
      send_bins(0, 15, 1'b1, 1'b0);
      check_counts("t4");

      // Gaps on alternate cycles; bin 15 = (-128,-128) beats bin 3 = (100,100)
      clear_frame();
      fre[3]  = 8'd100;
      fim[3]  = 8'd100;
      fre[15] = 8'h80;
      fim[15] = 8'h80;
      exp_push(4'd15, 16'd32768, 8'h80, 8'h80);
      send_bins(0, 15, 1'b1, 1'b1);
      check_counts("t5");

      // Reset during bin 8, then a fresh frame with bin 12 = (10,-1)
      clear_frame();
      fre[4] = 8'd120;
      send_bins(0, 7, 1'b0, 1'b0);
      aclr = 1'b1;
      tick();
      aclr = 1'b0;
      chk("mid_rst_state", 64'(state_dbg), 64'd0);
      clear_frame();
      fre[12] = 8'd10;
      fim[12] = 8'hFF;
      exp_push(4'd12, 16'd101, 8'd10, 8'hFF);
      send_bins(0, 15, 1'b1, 1'b0);
      check_counts("t6");

      // sop inside an open frame restarts; only the new frame reports
      clear_frame();
      fre[2] = 8'd50;
      fim[2] = 8'd50;
      send_bins(0, 5, 1'b0, 1'b0);
      clear_frame();
      fre[9] = 8'd2;
      fim[9] = 8'd2;
      exp_fe++;
      exp_push(4'd9, 16'd8, 8'd2, 8'd2);
      send_bins(0, 15, 1'b1, 1'b0);
      check_counts("t7");

      // Bin N-1 without eop: error, no result
      clear_frame();
      fre[1] = 8'd60;
      exp_fe++;
      send_bins(0, 15, 1'b0, 1'b0);
      check_counts("t8");

      // sop and eop on the same beat: error
      sink_valid = 1'b1;
      sink_sop = 1'b1;
      sink_eop = 1'b1;
      sink_Re = 8'd5;
      sink_Im = 8'd5;
      tick();
      sink_valid = 1'b0;
      sink_sop = 1'b0;
      sink_eop = 1'b0;
      exp_fe++;
      check_counts("t9");

      // DC handling: bin 0 = (100,0), bin 3 = (1,0)
      clear_frame();
      fre[0] = 8'd100;
      fre[3] = 8'd1;
`ifdef FFT_PEAK_SKIP_DC_EN
      exp_push(4'd3, 16'd1, 8'd1, 8'd0);
`else
      exp_push(4'd0, 16'd10000, 8'd100, 8'd0);
`endif
      send_bins(0, 15, 1'b1, 1'b0);
      check_counts("t10");

      idle(5);
      chk("sb_empty", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/fft_peak_find.md
FFT_PEAK_FIND -- requirements
Module: fft_peak_find

Interface
REQ-001 SHALL have parameter POW, default 12, meaning frame length N = 2**POW bins.
REQ-002 SHALL have parameter RES_WIDTH, default 26, meaning the signed width of the incoming spectrum samples.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port aclr, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port sink_sop, input, 1 bit: first bin of a frame; qualified by sink_valid.
REQ-006 SHALL have port sink_eop, input, 1 bit: last bin of a frame; qualified by sink_valid.
REQ-007 SHALL have port sink_valid, input, 1 bit: the current beat is valid.
REQ-008 SHALL have ports sink_Re and sink_Im, input, RES_WIDTH bits each, signed: the bin value.
REQ-009 SHALL have port peak_valid, output, 1 bit: one-cycle result strobe.
REQ-010 SHALL have port peak_bin, output, POW bits: index of the peak bin.
REQ-011 SHALL have port peak_pwr, output, 2*RES_WIDTH bits, unsigned: Re^2+Im^2 of the peak.
REQ-012 SHALL have ports peak_Re and peak_Im, output, RES_WIDTH bits each, signed: the raw value of the peak bin.
REQ-013 SHALL have port frame_error, output, 1 bit: one-cycle strobe on a framing violation.

Function
REQ-014 SHALL compute pwr = Re*Re + Im*Im at full precision, 2*RES_WIDTH bits, with no truncation or saturation.
REQ-015 SHALL use a two-state FSM: IDLE and FRAME.
REQ-016 In IDLE, a valid beat with sop SHALL enter FRAME, set the bin counter to 0 and load that beat as the running max; valid beats without sop SHALL be ignored.
REQ-017 In FRAME, each valid beat SHALL increment the bin counter; beats with sink_valid low SHALL change no state.
REQ-018 A bin SHALL replace the running max only if its pwr is strictly greater; on ties the lowest bin index wins.
REQ-019 A valid eop beat at counter N-1 SHALL close the frame, return to IDLE, and pulse peak_valid exactly 3 clk cycles after that beat.
REQ-020 A valid eop beat at any other count SHALL pulse frame_error, discard the frame and return to IDLE.
REQ-021 A valid beat at count N-1 without eop SHALL pulse frame_error, discard the frame and return to IDLE.
REQ-022 A valid sop beat in FRAME SHALL pulse frame_error, discard the open frame and start a new frame with that beat as bin 0.
REQ-023 A beat with both sop and eop set SHALL be treated as an eop violation whenever N > 1.
REQ-024 peak_bin, peak_pwr, peak_Re and peak_Im SHALL hold their values until the next peak_valid.
REQ-025 frame_error SHALL assert 3 cycles after the offending beat, aligned with the peak_valid timing.
REQ-026 The block SHALL accept a valid beat every cycle, with no backpressure.

Reset
REQ-027 While aclr is high at a clk edge, the FSM SHALL go to IDLE and the bin counter and pipeline valid bits SHALL clear.
REQ-028 All outputs SHALL reset to 0.
REQ-029 Reset asserted mid-frame SHALL drop the frame and any in-flight result; no peak_valid or frame_error SHALL be produced for it.

Configuration
REQ-030 With macro FFT_PEAK_SKIP_DC_EN defined, bin 0 SHALL be excluded from the search: the running max is initialised from bin 1 and peak_bin is never 0 for a completed frame.
REQ-031 Without FFT_PEAK_SKIP_DC_EN, all N bins SHALL be candidates.

Structure
REQ-032 Package fft_pkg SHALL hold the FSM state enum and the pipeline latency constant (3).
REQ-033 Sub-module fft_peak_pwr SHALL implement the pipelined magnitude-squared calculation (registered square, then registered sum), with sop, eop and valid delayed alongside the data.
REQ-034 The compare, FSM and output registers SHALL be the third pipeline stage.

Verification (POW=4, RES_WIDTH=8)
REQ-035 A 16-bin frame with all bins 0 except bin 5 = (3,4) SHALL produce peak_valid 3 cycles after eop, peak_bin=5, peak_pwr=25, peak_Re=3, peak_Im=4.
REQ-036 Bins 2 and 9 both = (-7,0), all others 0, SHALL produce peak_bin=2 and peak_pwr=49.
REQ-037 eop at bin 10 SHALL produce frame_error, no peak_valid, and a following good frame reporting correctly.
REQ-038 A frame with sink_valid low on alternating cycles and bin 15 = (-128,-128) SHALL produce peak_bin=15 and peak_pwr=32768.
REQ-039 aclr high for 1 cycle at bin 8, followed by a fresh frame, SHALL produce no output for the aborted frame and a correct result for the new one.
REQ-040 With FFT_PEAK_SKIP_DC_EN defined, bin 0 = (100,0) and bin 3 = (1,0) SHALL produce peak_bin=3; without the macro, peak_bin=0.
